// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, controller FSM encoding and default data width.
package alu_pkg;

  localparam int DATA_WIDTH = 16;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_AND = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU; all results truncated to DATA_WIDTH, division by zero yields all-ones.
module alu #(
  parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH
) (
  input  logic [2:0]            oc,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] f
);
  import alu_pkg::*;

  always_comb begin
    f = '0;
    case (oc)
      OP_ADD: f = a + b;
      OP_SUB: f = a - b;
      OP_MUL: f = a * b;
      OP_DIV: f = (b == '0) ? '1 : a / b;
      OP_NOT: f = ~a;
      OP_XOR: f = a ^ b;
      OP_OR:  f = a | b;
      OP_AND: f = a & b;
      default: f = '0;
    endcase
  end

endmodule

// File: rtl/alu_ctrl.sv
// Request/response controller for the ALU with a chaining accumulator.
// Optional ALU_CTRL_DIVZERO_EN forces all-ones plus an error flag on divide by zero.
module alu_ctrl #(
  parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_oc,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  input  logic                  req_use_acc,
  output logic [2:0]            alu_oc,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_f,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_f,
  output logic                  rsp_err,
  output logic                  busy
);
  import alu_pkg::*;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] exec_f;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_valid) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decode state only, never the incoming valid/ready.
  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign busy      = (state_q != ST_IDLE);

`ifdef ALU_CTRL_DIVZERO_EN
  logic div_zero;
  assign div_zero = (alu_oc == OP_DIV) && (alu_b == '0);
  assign exec_f   = div_zero ? '1 : alu_f;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  rsp_err <= 1'b0;
    else if (state_q == ST_EXEC) rsp_err <= div_zero;
  end
`else
  assign exec_f  = alu_f;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_oc <= '0;
      alu_a  <= '0;
      alu_b  <= '0;
      acc    <= '0;
      rsp_f  <= '0;
    end else begin
      if (state_q == ST_IDLE && req_valid) begin
        alu_oc <= req_oc;
        alu_a  <= req_use_acc ? acc : req_a;
        alu_b  <= req_b;
      end
      // acc only moves on EXEC->RESP, so a stalled consumer cannot disturb it.
      if (state_q == ST_EXEC) begin
        rsp_f <= exec_f;
        acc   <= exec_f;
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl driving the real alu, with a reference model of the op rules.
module tb_alu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_use_acc;
  logic [2:0]  req_oc, alu_oc;
  logic [15:0] req_a, req_b, alu_a, alu_b, alu_f, rsp_f;
  logic        rsp_valid, rsp_ready, rsp_err, busy;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] acc_m = 16'h0;

  always #5 clk = ~clk;

  alu #(.DATA_WIDTH(16)) u_alu (.oc(alu_oc), .a(alu_a), .b(alu_b), .f(alu_f));

  alu_ctrl #(.DATA_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_oc(req_oc),
    .req_a(req_a), .req_b(req_b), .req_use_acc(req_use_acc),
    .alu_oc(alu_oc), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_f(rsp_f),
    .rsp_err(rsp_err), .busy(busy)
  );

  function automatic logic [15:0] ref_f(input logic [2:0] oc, input logic [15:0] a, input logic [15:0] b);
    longint ua, ub;
    ua = longint'(a);
    ub = longint'(b);
    case (oc)
      3'd0: return 16'((ua + ub) % 65536);
      3'd1: return 16'((ua - ub + 65536) % 65536);
      3'd2: return 16'((ua * ub) % 65536);
      3'd3: return (ub == 0) ? 16'hFFFF : 16'(ua / ub);
      3'd4: return 16'(65535 - ua);
      3'd5: return a ^ b;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic ref_err(input logic [2:0] oc, input logic [15:0] b);
`ifdef ALU_CTRL_DIVZERO_EN
    return (oc == 3'd3) && (b == 16'h0);
`else
    return 1'b0 && (oc == 3'd3) && (b == 16'h0);
`endif
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction: accept, EXEC, RESP with optional stall and ignored request pulses.
  task automatic run_op(input logic [2:0] oc, input logic [15:0] a, input logic [15:0] b,
                        input logic use_acc, input int stall, input string tag);
    logic [15:0] ea, ef;
    logic        ee;
    ea = use_acc ? acc_m : a;
    ef = ref_f(oc, ea, b);
    ee = ref_err(oc, b);
    @(negedge clk);
    check({tag, " idle_ready"}, 16'(req_ready), 16'h1);
    check({tag, " idle_busy"}, 16'(busy), 16'h0);
    req_valid = 1'b1; req_oc = oc; req_a = a; req_b = b; req_use_acc = use_acc;
    @(negedge clk);
    req_valid = 1'b0; req_a = 16'($urandom); req_b = 16'($urandom); req_use_acc = 1'($urandom);
    check({tag, " alu_oc"}, 16'(alu_oc), 16'(oc));
    check({tag, " alu_a"}, alu_a, ea);
    check({tag, " alu_b"}, alu_b, b);
    check({tag, " exec_busy"}, 16'(busy), 16'h1);
    check({tag, " exec_rsp_valid"}, 16'(rsp_valid), 16'h0);
    check({tag, " exec_ready"}, 16'(req_ready), 16'h0);
    @(negedge clk);
    check({tag, " rsp_valid"}, 16'(rsp_valid), 16'h1);
    check({tag, " rsp_f"}, rsp_f, ef);
    check({tag, " rsp_err"}, 16'(rsp_err), 16'(ee));
    check({tag, " resp_busy"}, 16'(busy), 16'h1);
    for (int i = 0; i < stall; i++) begin
      req_valid = 1'($urandom);
      @(negedge clk);
      check({tag, " stall_valid"}, 16'(rsp_valid), 16'h1);
      check({tag, " stall_f"}, rsp_f, ef);
      check({tag, " stall_err"}, 16'(rsp_err), 16'(ee));
      check({tag, " stall_ready"}, 16'(req_ready), 16'h0);
      check({tag, " stall_alu_a"}, alu_a, ea);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, " done_valid"}, 16'(rsp_valid), 16'h0);
    check({tag, " done_busy"}, 16'(busy), 16'h0);
    check({tag, " hold_alu_b"}, alu_b, b);
    acc_m = ef;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " alu_oc"}, 16'(alu_oc), 16'h0);
    check({tag, " alu_a"}, alu_a, 16'h0);
    check({tag, " alu_b"}, alu_b, 16'h0);
    check({tag, " rsp_f"}, rsp_f, 16'h0);
    check({tag, " rsp_valid"}, 16'(rsp_valid), 16'h0);
    check({tag, " rsp_err"}, 16'(rsp_err), 16'h0);
    check({tag, " busy"}, 16'(busy), 16'h0);
  endtask

  initial begin
    logic [15:0] sweep_a, sweep_b;
    rst_n = 1'b0;
    req_valid = 1'b0; req_oc = 3'd0; req_a = 16'h0; req_b = 16'h0; req_use_acc = 1'b0;
    rsp_ready = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset req_ready", 16'(req_ready), 16'h1);

    run_op(3'd0, 16'd5, 16'd7, 1'b0, 0, "add");
    run_op(3'd1, 16'd10, 16'd3, 1'b0, 0, "chain_sub");
    run_op(3'd2, 16'hDEAD, 16'd6, 1'b1, 0, "chain_mul");
    check("chain_mul acc", acc_m, 16'd42);
    run_op(3'd4, 16'h1234, 16'h0, 1'b1, 1, "chain_not");
    check("chain_not acc", acc_m, 16'hFFD5);
    run_op(3'd0, 16'hFFFF, 16'h0001, 1'b0, 5, "wrap_stall");
    run_op(3'd3, 16'd9, 16'd0, 1'b0, 2, "div0");
    run_op(3'd3, 16'd9, 16'd2, 1'b0, 0, "div");

    // Reset in the middle of EXEC drops the operation entirely.
    @(negedge clk);
    req_valid = 1'b1; req_oc = 3'd5; req_a = 16'h00FF; req_b = 16'h0F0F; req_use_acc = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    check("midop exec_busy", 16'(busy), 16'h1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midop");
    @(negedge clk);
    rst_n = 1'b1;
    acc_m = 16'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midop no_rsp", 16'(rsp_valid), 16'h0);
      check("midop ready", 16'(req_ready), 16'h1);
    end
    run_op(3'd0, 16'h7777, 16'h0001, 1'b1, 0, "post_reset");

    sweep_a = 16'h00F0;
    sweep_b = 16'h0030;
    for (int k = 0; k < 8; k++) begin
      run_op(3'(k), sweep_a, sweep_b, 1'b0, 0, $sformatf("sweep%0d", k));
    end

    for (int r = 0; r < 25; r++) begin
      logic [15:0] rb;
      rb = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      run_op(3'($urandom_range(0, 7)), 16'($urandom), rb, 1'($urandom),
             int'($urandom_range(0, 3)), $sformatf("rand%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_ctrl.md
# alu_ctrl

Request-side controller for the combinational ALU. It accepts one operation at a time over a valid/ready request channel and drives the ALU's opcode and operand inputs from registers. It captures the ALU result and returns it over a valid/ready response channel. It sits between the instruction/control path and the ALU at the top level, and holds an accumulator so operations can be chained.

## Interface
- DATA_WIDTH, 16, operand/result width
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous reset, active-low
- req_valid  input  1  request present
- req_ready  output  1  controller can accept a request
- req_oc  input  3  opcode: 000 add, 001 sub, 010 mul, 011 div, 100 not(a), 101 xor, 110 or, 111 and
- req_a  input  DATA_WIDTH  operand A (ignored when req_use_acc=1)
- req_b  input  DATA_WIDTH  operand B
- req_use_acc  input  1  take operand A from the accumulator
- alu_oc  output  3  opcode to ALU
- alu_a, alu_b  output  DATA_WIDTH  operands to ALU
- alu_f  input  DATA_WIDTH  ALU result
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer takes response
- rsp_f  output  DATA_WIDTH  result
- rsp_err  output  1  error flag (see Configuration)
- busy  output  1  high in any state other than IDLE

## Operation
- The FSM has three states: IDLE, EXEC and RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, register oc into alu_oc and b into alu_b.
  - Register a into alu_a: a = req_use_acc ? acc : req_a.
  - Go to EXEC.
- EXEC (exactly 1 cycle):
  - alu_* are stable.
  - Register alu_f into rsp_f and into acc.
  - Compute rsp_err.
  - Go to RESP.
- RESP:
  - rsp_valid=1.
  - rsp_f and rsp_err are held stable until rsp_valid&&rsp_ready, then go to IDLE.
  - req_ready=0, so a new request is never accepted in the same cycle as the response handshake.
- alu_* hold their last values outside EXEC. They are not cleared after an operation.
- Arithmetic:
  - The result is whatever the ALU returns, truncated modulo 2^DATA_WIDTH.
  - mul keeps the low DATA_WIDTH bits.
  - The controller never widens or sign-interprets values.
- The accumulator updates only on the EXEC→RESP transition. A consumer stalling in RESP does not disturb acc.
- An undefined req_oc is impossible because the field is 3 bits and all 8 codes are defined.
- Reset, asynchronous at any time, including mid-EXEC or mid-RESP:
  - The in-flight operation is dropped and no response is issued.
  - state=IDLE.
  - acc, alu_oc, alu_a, alu_b, rsp_f all 0.
  - rsp_valid=0, rsp_err=0, busy=0, req_ready=1 once reset is released.

## Timing
- Request accepted at edge N; alu_* valid from N to N+1.
- rsp_valid rises after edge N+1, so request-to-response latency is 2 cycles.
- Throughput: at best one operation per 3 cycles (accept, EXEC, response handshake).
- req_ready and rsp_valid are decoded from state registers only. There is no combinational path from req_valid or rsp_ready to any output.
- alu_f is sampled only at the end of EXEC. The ALU path must close within one clock period.

## Configuration
- ALU_CTRL_DIVZERO_EN:
  - When defined, an opcode of 011 with alu_b==0 makes EXEC load rsp_f={DATA_WIDTH{1'b1}} and rsp_err=1 instead of alu_f.
  - acc is still loaded with all-ones.
  - For every other case, rsp_err=0.
- When ALU_CTRL_DIVZERO_EN is not defined:
  - rsp_err is tied to 0.
  - Division by zero returns whatever alu_f presents.

## Structure
- Shared package alu_pkg holds:
  - opcode localparams (OP_ADD…OP_AND, 3-bit);
  - FSM state encoding (ST_IDLE, ST_EXEC, ST_RESP);
  - the DATA_WIDTH default.
- The ALU itself and this controller both import the opcodes from alu_pkg.
- No sub-module: the ALU is instantiated beside alu_ctrl at the top level and connected through alu_oc/alu_a/alu_b/alu_f.
- The test bench instantiates the real alu behind it.

## Test plan
- Basic add: request oc=000, a=5, b=7, rsp_ready=1 → rsp_valid exactly 2 cycles after accept, rsp_f=12, rsp_err=0; busy high for 2 cycles, then low.
- Chaining: sub a=10, b=3 (rsp 7), then mul with use_acc=1, b=6 → alu_a=7, rsp_f=42. Then not with use_acc=1 → rsp_f=16'hFFD5.
- Back-pressure: add 16'hFFFF+1 with rsp_ready held 0 for 5 cycles → rsp_f=0 (wrap) held stable, req_ready=0 throughout, and a req_valid pulse during RESP is ignored.
- Divide by zero: div a=9, b=0.
  - With ALU_CTRL_DIVZERO_EN: rsp_f=16'hFFFF, rsp_err=1.
  - Without it: rsp_err=0.
  - In both builds, div a=9, b=2 returns 4.
- Reset mid-op: assert rst_n=0 during EXEC of xor a=16'h00FF, b=16'h0F0F → all outputs 0 immediately. After release, no rsp_valid appears; a following use_acc add with b=1 returns 1.
- Opcode sweep: all 8 opcodes with a=16'h00F0, b=16'h0030 → results match the ALU encoding: 0120, 00C0, 2D00, 0005, FF0F, 00C0, 00F0, 0030.
